// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank: working-register bank feeding the datapath MUX.
//
// Holds six registers L, W, K, T, X, J and drives them continuously. Each
// clock edge a register may be cleared, written or incremented, with that
// priority. Operations on different registers in the same cycle are
// independent. The select encoding matches the MUX, so one decode serves both.
//
// Optional feature macro: REG_BANK_ZFLAG_EN
//   Adds the registered per-register zero flags on port zflag.
//
// Ports:
//   clk        system clock, rising edge active
//   rst        asynchronous reset, active-high
//   wr_en      write strobe
//   wr_sel     write target (111 L, 010 W, 011 K, 001 T, 101 X, 110 J)
//   wr_data    write value
//   inc_en     increment strobe
//   inc_sel    increment target, same encoding as wr_sel
//   clr_mask   per-register synchronous clear (bit0 L .. bit5 J)
//   L..J       registered contents
//   wrap       one-cycle pulse when an executed increment carried out
//   zflag      per-register zero flags (only with REG_BANK_ZFLAG_EN)
// ---------------------------------------------------------------------------
module reg_bank #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned INC_STEP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inc_en,
    input  logic [2:0]            inc_sel,
    input  logic [5:0]            clr_mask,
    output logic [DATA_WIDTH-1:0] L,
    output logic [DATA_WIDTH-1:0] W,
    output logic [DATA_WIDTH-1:0] K,
    output logic [DATA_WIDTH-1:0] T,
    output logic [DATA_WIDTH-1:0] X,
    output logic [DATA_WIDTH-1:0] J,
    output logic                  wrap
`ifdef REG_BANK_ZFLAG_EN
    ,
    output logic [5:0]            zflag
`endif
);

    localparam int unsigned NumRegs = 6;

    // Step truncated to the register width before the add.
    localparam logic [DATA_WIDTH-1:0] IncStep = DATA_WIDTH'(INC_STEP);

    // Map a MUX select code to a one-hot register vector (bit order as
    // clr_mask). Codes 000 and 100 select nothing.
    function automatic logic [NumRegs-1:0] decode_sel(input logic [2:0] sel);
        logic [NumRegs-1:0] hit;
        hit = '0;
        case (sel)
            3'b111:  hit = 6'b000001; // L
            3'b010:  hit = 6'b000010; // W
            3'b011:  hit = 6'b000100; // K
            3'b001:  hit = 6'b001000; // T
            3'b101:  hit = 6'b010000; // X
            3'b110:  hit = 6'b100000; // J
            default: hit = '0;
        endcase
        return hit;
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NumRegs];
    logic [DATA_WIDTH-1:0] regs_d [NumRegs];
    logic                  wrap_q;
    logic                  wrap_d;
    logic [NumRegs-1:0]    wr_hit;
    logic [NumRegs-1:0]    inc_hit;
    logic [DATA_WIDTH:0]   sum [NumRegs];

    assign wr_hit  = wr_en  ? decode_sel(wr_sel)  : '0;
    assign inc_hit = inc_en ? decode_sel(inc_sel) : '0;

    always_comb begin
        wrap_d = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            sum[i]    = {1'b0, regs_q[i]} + {1'b0, IncStep};
            regs_d[i] = regs_q[i];
            if (clr_mask[i]) begin
                regs_d[i] = '0;
            end else if (wr_hit[i]) begin
                regs_d[i] = wr_data;
            end else if (inc_hit[i]) begin
                regs_d[i] = sum[i][DATA_WIDTH-1:0];
                // Only an increment that actually lands may report a carry.
                wrap_d    = wrap_d | sum[i][DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wrap_q <= wrap_d;
        end
    end

`ifdef REG_BANK_ZFLAG_EN
    // Flags are taken from next-state values so they line up with the
    // register outputs in the same cycle.
    logic [NumRegs-1:0] zflag_q;
    logic [NumRegs-1:0] zflag_d;

    always_comb begin
        zflag_d = '0;
        for (int i = 0; i < NumRegs; i++) begin
            zflag_d[i] = (regs_d[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zflag_q <= '0;
        end else begin
            zflag_q <= zflag_d;
        end
    end

    assign zflag = zflag_q;
`endif

    assign L    = regs_q[0];
    assign W    = regs_q[1];
    assign K    = regs_q[2];
    assign T    = regs_q[3];
    assign X    = regs_q[4];
    assign J    = regs_q[5];
    assign wrap = wrap_q;

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Working-register bank that sits directly upstream of the processor datapath MUX.
- Holds the six 24-bit registers L, W, K, T, X and J, and drives them continuously onto the MUX inputs.
- Supports a bus write, a single-register increment (address/loop counters) and a masked clear in the same cycle.
- Uses the same 3-bit select encoding as the MUX, so control logic reuses one decode.

Parameters:
- DATA_WIDTH, 24, width of every register and of wr_data.
- INC_STEP, 1, unsigned amount added by an increment; truncated to DATA_WIDTH.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous reset, active-high.
- wr_en  input  1  write strobe.
- wr_sel  input  3  write target; encoding below.
- wr_data  input  DATA_WIDTH  write value.
- inc_en  input  1  increment strobe.
- inc_sel  input  3  increment target; same encoding.
- clr_mask  input  6  per-register synchronous clear; bit0 L, 1 W, 2 K, 3 T, 4 X, 5 J.
- L, W, K, T, X, J  output  DATA_WIDTH each  registered contents; feed the MUX.
- wrap  output  1  one-cycle pulse, asserted when an increment overflowed.
- zflag  output  6  per-register zero flags; present only with REG_BANK_ZFLAG_EN.

Behaviour:
- Select encoding: 111 L, 010 W, 011 K, 001 T, 101 X, 110 J. Code 000 and code 100 select no register. A write or increment addressed to either code is ignored and has no side effects.
- Reset:
  - rst high asynchronously forces all six registers, wrap and zflag to 0.
  - Reset takes effect immediately, including mid-operation; any in-flight write or increment is lost.
  - First update happens on the first rising clk edge after rst deasserts.
- Latency: every update lands on the next rising edge; outputs are register-driven with no combinational input-to-output path.
- Per-register priority on each edge, highest first:
  - clear (its clr_mask bit is 1) -> register becomes 0.
  - write (wr_en=1 and wr_sel selects it) -> register becomes wr_data.
  - increment (inc_en=1 and inc_sel selects it) -> register becomes (register + INC_STEP) mod 2^DATA_WIDTH.
  - otherwise hold.
- Operations on different registers in the same cycle all take effect independently.
- Increment arithmetic: unsigned; the carry-out is discarded from the register.
- wrap:
  - Next-cycle value is 1 only when an increment actually executed and its carry-out was 1.
  - An increment suppressed by a write or clear does not assert wrap.
  - wrap is 0 in all other cycles and is never sticky.
- The bank has no handshake and no stall; the controller owns sequencing.

Optional Feature:
- Macro: REG_BANK_ZFLAG_EN.
- Defined:
  - zflag[i] is registered and computed from each register's next-state value, so it is cycle-aligned with the register outputs (bit order as clr_mask).
  - All zflag bits reset to 0.
- Undefined: the zflag port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset and hold: assert rst mid-cycle -> all outputs read 0 immediately. Release rst, keep all strobes idle for 3 cycles -> all outputs still 0, wrap 0.
2. Write each register: wr_en=1 with wr_sel=111/010/011/001/101/110 and data 64/256/32/128/160/32 on consecutive edges -> each value appears on L/W/K/T/X/J one cycle later. wr_sel=000 with data 99 -> no register changes.
3. Increment wrap: write X=24'hFFFFFE, then inc X twice -> X=24'hFFFFFF with wrap=0, then X=0 with wrap=1 for exactly one cycle. With REG_BANK_ZFLAG_EN defined, zflag[4]=1 in the same cycle.
4. Priority on one register:
   - T=5; in the same cycle wr_sel=001 with data 40 and inc_sel=001 -> T=40 and wrap stays 0.
   - Next cycle clr_mask=6'b001000 together with a write of 77 to T -> T=0.
5. Parallel operations: L=10 and K=20; in one cycle write W=300, inc L and clear K -> next cycle L=11, W=300, K=0, all other registers unchanged.
6. Reset mid-operation: start an inc of J=7 and assert rst asynchronously before the edge -> J=0. After release, an inc gives J=1.
